// File: rtl/grf_mp_if.sv
// grf_mp_if: bundle of the register-file read, write and scoreboard signals.
//   ra/rd/rd_ready : NR read ports (address in, data and ready out)
//   we/wa/wd       : NW write ports from writeback (port NW-1 is youngest)
//   set_en/set_addr: mark a register busy when its producer issues
//   busy_vec       : registered busy bit per register
// master = decode/writeback side driving the file, slave = the file itself.
interface grf_mp_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2,
  parameter int NW = 2
);
  logic [NR*AW-1:0]  ra;
  logic [NR*DW-1:0]  rd;
  logic [NR-1:0]     rd_ready;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  wa;
  logic [NW*DW-1:0]  wd;
  logic              set_en;
  logic [AW-1:0]     set_addr;
  logic [2**AW-1:0]  busy_vec;

  modport master (
    output ra, we, wa, wd, set_en, set_addr,
    input  rd, rd_ready, busy_vec
  );

  modport slave (
    input  ra, we, wa, wd, set_en, set_addr,
    output rd, rd_ready, busy_vec
  );
endinterface

// File: rtl/grf_mp.sv
// grf_mp: multi-ported general-purpose register file with write-through
// bypass, optional hardwired-zero register 0 and a per-register busy
// scoreboard.
//   clk   : rising-edge clock for all state
//   reset : asynchronous active-high, clears registers and busy bits
//   bus   : grf_mp_if slave port (read ports, write ports, set request,
//           busy_vec)
// The bus interface parameters must match DW/AW/NR/NW given here.
module grf_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        reset,
  grf_mp_if.slave     bus
);
  localparam int NREG = 2**AW;

  logic [NW-1:0]   wr_eff;
  logic [DW-1:0]   mem_q [NREG];
  logic [NREG-1:0] busy_q;

  // A write to register 0 is dropped entirely when it is hardwired to zero,
  // so it neither stores, bypasses nor clears a busy bit.
  for (genvar gi = 0; gi < NW; gi++) begin : g_wr
    assign wr_eff[gi] = bus.we[gi] &&
                        !((ZERO_REG != 0) && (bus.wa[gi*AW +: AW] == '0));
  end

  // Per-register write decode, storage and busy bit.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic          hit;
    logic [DW-1:0] data;
    logic          set_hit;
    logic [DW-1:0] val_reg;
    logic          busy_reg;
    logic          busy_next;

    // Ascending scan so the highest-index (youngest) port wins a conflict.
    always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int j = 0; j < NW; j++) begin
        if (wr_eff[j] && (bus.wa[j*AW +: AW] == AW'(gi))) begin
          hit  = 1'b1;
          data = bus.wd[j*DW +: DW];
        end
      end
    end

    assign set_hit = bus.set_en && (bus.set_addr == AW'(gi)) &&
                     !((ZERO_REG != 0) && (gi == 0));

    // A new producer issued this cycle outranks the older one retiring.
    always_comb begin
      busy_next = busy_reg;
      if (set_hit) begin
        busy_next = 1'b1;
      end else if (hit) begin
        busy_next = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        val_reg  <= '0;
        busy_reg <= 1'b0;
      end else begin
        if (hit) begin
          val_reg <= data;
        end
        busy_reg <= busy_next;
      end
    end

    assign mem_q[gi]  = val_reg;
    assign busy_q[gi] = busy_reg;
  end

  assign bus.busy_vec = busy_q;

  // Read ports: zero register, then same-cycle bypass, then stored value.
  for (genvar gi = 0; gi < NR; gi++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;
    logic [DW-1:0] data;
    logic          is_zero;

    assign addr    = bus.ra[gi*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);

    always_comb begin
      hit  = 1'b0;
      data = mem_q[addr];
      for (int j = 0; j < NW; j++) begin
        if (wr_eff[j] && (bus.wa[j*AW +: AW] == addr)) begin
          hit  = 1'b1;
          data = bus.wd[j*DW +: DW];
        end
      end
    end

    assign bus.rd[gi*DW +: DW] = is_zero ? '0 : data;
    // The bypass term lets a waiting consumer proceed in the very cycle its
    // producer writes back.
    assign bus.rd_ready[gi]    = is_zero || hit || !busy_q[addr];
  end
endmodule

// File: tb/tb_grf_mp.sv
// tb_grf_mp: directed and randomized check of grf_mp against a behavioural
// model (array of values plus busy set) computed from the register-file rules.
module tb_grf_mp;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 2;
  localparam int NW   = 2;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_mp_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) bus();

  grf_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_cyc = 0;

  logic [DW-1:0]   m_mem [NREG];
  logic [NREG-1:0] m_busy;

  logic [AW-1:0] t_ra [NR];
  logic [NW-1:0] t_we;
  logic [AW-1:0] t_wa [NW];
  logic [DW-1:0] t_wd [NW];
  logic          t_se;
  logic [AW-1:0] t_sa;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  function automatic logic wr_hit(input logic [AW-1:0] a);
    for (int j = 0; j < NW; j++)
      if (t_we[j] && t_wa[j] == a && a != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Youngest matching port supplies the data.
  function automatic logic [DW-1:0] wr_val(input logic [AW-1:0] a);
    for (int j = NW-1; j >= 0; j--)
      if (t_we[j] && t_wa[j] == a && a != 0) return t_wd[j];
    return '0;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_hit(a)) return wr_val(a);
    return m_mem[a];
  endfunction

  function automatic logic exp_ready(input logic [AW-1:0] a);
    return (a == 0) || wr_hit(a) || !m_busy[a];
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) m_mem[r] = '0;
    m_busy = '0;
  endtask

  task automatic model_update();
    logic [NREG-1:0] nb;
    logic [AW-1:0]   a;
    nb = m_busy;
    for (int r = 1; r < NREG; r++) begin
      a = AW'(r);
      if (t_se && t_sa == a) nb[r] = 1'b1;
      else if (wr_hit(a)) nb[r] = 1'b0;
      if (wr_hit(a)) m_mem[r] = wr_val(a);
    end
    m_busy = nb;
  endtask

  task automatic idle();
    for (int i = 0; i < NR; i++) t_ra[i] = '0;
    for (int j = 0; j < NW; j++) begin
      t_wa[j] = '0;
      t_wd[j] = '0;
    end
    t_we = '0;
    t_se = 1'b0;
    t_sa = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) bus.ra[i*AW +: AW] = t_ra[i];
    for (int j = 0; j < NW; j++) begin
      bus.wa[j*AW +: AW] = t_wa[j];
      bus.wd[j*DW +: DW] = t_wd[j];
    end
    bus.we       = t_we;
    bus.set_en   = t_se;
    bus.set_addr = t_sa;
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NR; i++) begin
      check($sformatf("rd%0d", i), 64'(bus.rd[i*DW +: DW]), 64'(exp_rd(t_ra[i])));
      check($sformatf("rd_ready%0d", i), 64'(bus.rd_ready[i]), 64'(exp_ready(t_ra[i])));
    end
    check("busy_vec", 64'(bus.busy_vec), 64'(m_busy));
  endtask

  task automatic tick();
    check_outputs();
    $display("cyc %0d rst=%b we=%b wa=%0d/%0d wd=%h/%h set=%b@%0d ra=%0d/%0d rd=%h rdy=%b busy=%h",
             n_cyc, reset, t_we, t_wa[0], t_wa[1], t_wd[0], t_wd[1], t_se, t_sa,
             t_ra[0], t_ra[1], bus.rd, bus.rd_ready, bus.busy_vec);
    n_cyc++;
    @(posedge clk);
    if (!reset) model_update();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_clear();
    drive();
    #2;
    check("reset_busy_vec", 64'(bus.busy_vec), 64'h0);
    check("reset_ready", 64'(bus.rd_ready), 64'h3);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Bypass then stored value.
    idle(); t_we = 2'b01; t_wa[0] = 5'd3; t_wd[0] = 32'h12345678; t_ra[1] = 5'd3;
    settle(); check("bypass_r3", 64'(bus.rd[2*DW-1:DW]), 64'h12345678); tick();
    idle(); t_ra[1] = 5'd3;
    settle(); check("stored_r3", 64'(bus.rd[2*DW-1:DW]), 64'h12345678); tick();

    // Conflict: port 1 wins.
    idle(); t_we = 2'b11; t_wa[0] = 5'd7; t_wa[1] = 5'd7; t_wd[0] = 32'h1; t_wd[1] = 32'h2; t_ra[0] = 5'd7;
    settle(); check("conflict_bypass", 64'(bus.rd[DW-1:0]), 64'h2); tick();
    idle(); t_ra[0] = 5'd7;
    settle(); check("conflict_store", 64'(bus.rd[DW-1:0]), 64'h2); tick();

    // Zero register ignores writes and sets.
    idle(); t_we = 2'b01; t_wa[0] = 5'd0; t_wd[0] = 32'hFFFFFFFF; t_se = 1'b1; t_sa = 5'd0;
    settle(); check("zero_rd", 64'(bus.rd[DW-1:0]), 64'h0); check("zero_ready", 64'(bus.rd_ready[0]), 64'h1); tick();
    idle();
    settle(); check("zero_busy", 64'(bus.busy_vec[0]), 64'h0); check("zero_rd_after", 64'(bus.rd[DW-1:0]), 64'h0); tick();

    // Scoreboard on r9.
    idle(); t_se = 1'b1; t_sa = 5'd9; t_ra[0] = 5'd9;
    settle(); check("set_same_cycle_ready", 64'(bus.rd_ready[0]), 64'h1); tick();
    idle(); t_ra[0] = 5'd9;
    settle(); check("r9_busy", 64'(bus.busy_vec[9]), 64'h1); check("r9_not_ready", 64'(bus.rd_ready[0]), 64'h0); tick();
    idle(); t_we = 2'b10; t_wa[1] = 5'd9; t_wd[1] = 32'hAB; t_ra[0] = 5'd9;
    settle(); check("r9_ready_bypass", 64'(bus.rd_ready[0]), 64'h1); check("r9_rd_bypass", 64'(bus.rd[DW-1:0]), 64'hAB);
    check("r9_still_busy", 64'(bus.busy_vec[9]), 64'h1); tick();
    idle(); t_ra[0] = 5'd9;
    settle(); check("r9_cleared", 64'(bus.busy_vec[9]), 64'h0); tick();

    // Set and clear in the same cycle: set wins, data still stored.
    idle(); t_se = 1'b1; t_sa = 5'd4; t_we = 2'b01; t_wa[0] = 5'd4; t_wd[0] = 32'h44;
    settle(); tick();
    idle(); t_ra[1] = 5'd4;
    settle(); check("collide_busy", 64'(bus.busy_vec[4]), 64'h1); check("collide_data", 64'(bus.rd[2*DW-1:DW]), 64'h44);
    check("collide_not_ready", 64'(bus.rd_ready[1]), 64'h0); tick();

    // Asynchronous reset mid-cycle.
    idle(); t_we = 2'b01; t_wa[0] = 5'd5; t_wd[0] = 32'hDEADBEEF; t_se = 1'b1; t_sa = 5'd11;
    settle(); tick();
    idle(); t_ra[0] = 5'd5; t_ra[1] = 5'd11;
    settle(); check("pre_reset_r5", 64'(bus.rd[DW-1:0]), 64'hDEADBEEF); check("pre_reset_busy11", 64'(bus.busy_vec[11]), 64'h1);
    reset = 1'b1;
    model_clear();
    #1;
    check("async_reset_rd_r5", 64'(bus.rd[DW-1:0]), 64'h0);
    check("async_reset_busy", 64'(bus.busy_vec), 64'h0);
    check("async_reset_ready", 64'(bus.rd_ready[1]), 64'h1);
    tick();
    idle(); t_we = 2'b01; t_wa[0] = 5'd6; t_wd[0] = 32'h66; t_ra[1] = 5'd6; t_se = 1'b1; t_sa = 5'd12;
    settle(); check("reset_bypass", 64'(bus.rd[2*DW-1:DW]), 64'h66); tick();
    reset = 1'b0;
    idle(); t_ra[1] = 5'd6;
    settle(); check("reset_write_ignored", 64'(bus.rd[2*DW-1:DW]), 64'h0); check("reset_set_ignored", 64'(bus.busy_vec), 64'h0); tick();

    // Randomized traffic, addresses biased to a small range for collisions.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++)
        t_ra[i] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      for (int j = 0; j < NW; j++) begin
        t_wa[j] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
        t_wd[j] = $urandom;
      end
      t_we = NW'($urandom);
      t_se = ($urandom_range(0, 2) == 0);
      t_sa = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      settle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/grf_mp.md
# grf_mp

Parametrised general-purpose register file for the pipelined CPU: configurable data width, register count, read-port count and write-port count, with write-through bypass, a hardwired-zero register and a per-register busy scoreboard. It sits in the decode stage. Read ports feed the operand muxes. Write ports are driven from writeback, where port NW-1 is the youngest stage. The scoreboard lets the hazard unit stall on operands whose producer is still in flight.

## Interface
Parameters:
- DW, 32, data width of each register
- AW, 5, address width; register count is 2**AW
- NR, 2, number of read ports
- NW, 2, number of write ports
- ZERO_REG, 1, if 1 register 0 reads as 0 and ignores writes and set requests

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all registers and busy bits immediately
- ra  in  NR*AW  read addresses; port i uses bits [i*AW +: AW]
- rd  out  NR*DW  read data; combinational
- rd_ready  out  NR  1 when read port i's value is valid this cycle; combinational
- we  in  NW  write enables
- wa  in  NW*AW  write addresses
- wd  in  NW*DW  write data
- set_en  in  1  marks register set_addr busy, meaning a producer has been issued
- set_addr  in  AW  register to mark busy
- busy_vec  out  2**AW  registered busy bit per register

## Operation
- **Storage.** The register array has 2**AW entries of DW bits each.
- **Effective write for port j.** A write is effective when we[j]=1 and not (ZERO_REG=1 and wa[j]=0).
- **Write conflict.** When several effective writes target the same address in one cycle, the highest-index port wins. Only its data is stored and bypassed.
- **Read data for port i.**
  - If ZERO_REG=1 and ra[i]=0: 0.
  - Else, if an effective write targets ra[i] this cycle: the winning port's wd, i.e. write-through bypass.
  - Else: the stored value.
- **Busy update on the clock edge, per register r.**
  - set_en=1 and set_addr=r, and the request is not ignored under ZERO_REG: busy[r] ← 1. A set takes priority over a clear in the same cycle, because the newer producer wins.
  - Else, an effective write to r: busy[r] ← 0.
  - Else: busy[r] holds.
- **Ready.** rd_ready[i] = !busy[ra[i]], OR an effective write to ra[i] this cycle, OR (ZERO_REG=1 and ra[i]=0).
- **Same-cycle set and read.** A set_en in the same cycle as a read does not affect that cycle's rd_ready, because the busy bit is registered.
- **Busy output.** busy_vec is the registered busy array. Bit 0 is constant 0 when ZERO_REG=1.

## Timing
- **Reset.** While reset=1, asynchronously and independent of clk:
  - all registers = 0 and busy_vec = 0;
  - rd = 0 for every port, except where the bypass supplies write data;
  - rd_ready = all 1, except where the bypass applies;
  - the array and busy bits ignore writes and sets.
- **Reset release.** Reset deassertion mid-operation discards any in-flight busy state. The first edge after release performs normal updates.
- **Write latency.** A write is visible on rd in the same cycle through the bypass, and from the array from the next cycle on.
- **Busy latency.**
  - busy_vec changes exactly one edge after set_en or the clearing write.
  - rd_ready falls in the cycle after set_en.
  - rd_ready rises in the same cycle as the clearing write, through the bypass term.
- **Combinational path.** No combinational path exists from rd to any input. rd and rd_ready depend combinationally only on ra, we, wa, wd and stored state.

## Test plan
- **Async reset.** Write 0xDEADBEEF to r5, then assert reset mid-cycle without a clock edge → rd of r5 reads 0 immediately and busy_vec = 0.
- **Bypass and store.** Port 0 writes r3 = 0x12345678 while read port 1 reads r3 → rd[1] = 0x12345678 in that cycle. After the edge, with we = 0, it still reads 0x12345678.
- **Write conflict.** Ports 0 and 1 both write r7, with 0x1 and 0x2 → bypass gives 0x2 and the stored value is 0x2.
- **Zero register.** With ZERO_REG=1, write r0 = 0xFFFFFFFF and set_en on r0 → rd of r0 = 0, rd_ready = 1, busy_vec[0] = 0.
- **Scoreboard sequence.**
  - set_en r9 at edge N → busy_vec[9] = 1 and rd_ready = 0 for reads of r9 after N.
  - Write r9 = 0xAB in cycle M → rd_ready = 1 and rd = 0xAB in cycle M, and busy_vec[9] = 0 after edge M.
- **Set and clear collision.** set_en r4 and a write to r4 in the same cycle → r4 stores the data and busy_vec[4] = 1 after the edge.
